// File: rtl/ltsm_sb_pkg.sv
// Shared sideband definitions for the MBTRAIN substate handshakes: message codes,
// lane-map encodings, the REPAIR initiator state set and small decode helpers.
package ltsm_sb_pkg;

    localparam logic [3:0] SB_NONE                   = 4'b0000;
    localparam logic [3:0] SB_INIT_REQUEST           = 4'b0001;
    localparam logic [3:0] SB_INIT_RESPONSE          = 4'b0010;
    localparam logic [3:0] SB_END_REQUEST            = 4'b0101;
    localparam logic [3:0] SB_END_RESPONSE           = 4'b0110;
    localparam logic [3:0] SB_APPLY_DEGRADE_REQUEST  = 4'b0111;
    localparam logic [3:0] SB_APPLY_DEGRADE_RESPONSE = 4'b1000;

    localparam logic [2:0] LANES_NONE   = 3'b000;
    localparam logic [2:0] LANES_FIRST  = 3'b001;
    localparam logic [2:0] LANES_SECOND = 3'b010;
    localparam logic [2:0] LANES_BOTH   = 3'b011;

    localparam int unsigned TIMEOUT_CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE              = 3'd0,
        ST_SEND_INIT_REQ     = 3'd1,
        ST_WAIT_INIT_RESP    = 3'd2,
        ST_SEND_DEGRADE_REQ  = 3'd3,
        ST_WAIT_DEGRADE_RESP = 3'd4,
        ST_SEND_END_REQ      = 3'd5,
        ST_WAIT_END_RESP     = 3'd6,
        ST_TEST_FINISH       = 3'd7
    } repair_tx_state_e;

    function automatic logic [2:0] lane_encoding(input logic first_ok, input logic second_ok);
        logic [2:0] enc;
        case ({second_ok, first_ok})
            2'b11:   enc = LANES_BOTH;
            2'b01:   enc = LANES_FIRST;
            2'b10:   enc = LANES_SECOND;
            default: enc = LANES_NONE;
        endcase
        return enc;
    endfunction

    function automatic logic is_send_state(input repair_tx_state_e st);
        return (st == ST_SEND_INIT_REQ) || (st == ST_SEND_DEGRADE_REQ) || (st == ST_SEND_END_REQ);
    endfunction

    function automatic logic is_wait_state(input repair_tx_state_e st);
        return (st == ST_WAIT_INIT_RESP) || (st == ST_WAIT_DEGRADE_RESP) || (st == ST_WAIT_END_RESP);
    endfunction

    function automatic logic [3:0] request_code(input repair_tx_state_e st);
        logic [3:0] code;
        case (st)
            ST_SEND_INIT_REQ:    code = SB_INIT_REQUEST;
            ST_SEND_DEGRADE_REQ: code = SB_APPLY_DEGRADE_REQUEST;
            ST_SEND_END_REQ:     code = SB_END_REQUEST;
            default:             code = SB_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ltsm_timeout_cnt.sv
// Clear/enable/expire cycle counter shared by the MBTRAIN substate handshakes.
// o_expire flags the enabled cycle in which the count sits at LIMIT-1.
module ltsm_timeout_cnt #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LIMIT = 8000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles; clear wins so each new request starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expire = i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/repair_tx.sv
// Initiator half of the MBTRAIN.REPAIR handshake: sends INIT, APPLY_DEGRADE and END
// requests over the shared sideband and waits for each partner response.
module repair_tx
    import ltsm_sb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 8000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_local_first_8_lanes_ok,
    input  logic       i_local_second_8_lanes_ok,
    input  logic [3:0] i_sideband_message,
    input  logic       i_sideband_valid,
    input  logic       i_busy_negedge_detected,
    input  logic       i_valid_rx,
    output logic [3:0] o_sideband_message,
    output logic [2:0] o_sideband_data_lanes_encoding,
    output logic       o_valid_tx,
    output logic       o_test_ack,
    output logic       o_degrade_fail,
    output logic       o_timeout
);

    repair_tx_state_e r_state;
    repair_tx_state_e w_state_nxt;

    logic [3:0] r_msg;
    logic [2:0] r_enc;
    logic       r_pending;
    logic       r_valid_tx;
    logic       r_test_ack;
    logic       r_degrade_fail;
    logic       r_timeout;

    logic [3:0] w_msg_nxt;
    logic [2:0] w_enc_nxt;
    logic [2:0] w_enc_local;
    logic       w_pending_nxt;
    logic       w_valid_nxt;
    logic       w_ack_nxt;
    logic       w_fail_nxt;
    logic       w_timeout_nxt;
    logic       w_cnt_clear;
    logic       w_cnt_enable;
    logic       w_expire;
    logic       w_busy_done;
    logic       w_go_timeout;

    assign w_busy_done  = i_busy_negedge_detected && r_valid_tx;
    assign w_cnt_enable = is_send_state(r_state) || is_wait_state(r_state);
    assign w_enc_local  = lane_encoding(i_local_first_8_lanes_ok, i_local_second_8_lanes_ok);

    ltsm_timeout_cnt #(
        .WIDTH (TIMEOUT_CNT_WIDTH),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_enable),
        .o_expire (w_expire)
    );

    // Next-state and next-output decode; normal transitions take priority over expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_msg_nxt     = r_msg;
        w_enc_nxt     = r_enc;
        w_pending_nxt = r_pending;
        w_valid_nxt   = r_valid_tx;
        w_ack_nxt     = r_test_ack;
        w_fail_nxt    = r_degrade_fail;
        w_timeout_nxt = r_timeout;
        w_cnt_clear   = 1'b0;
        w_go_timeout  = 1'b0;

        // TX request only launches while the responder half leaves the sideband free.
        if (r_pending && !i_valid_rx) begin
            w_valid_nxt   = 1'b1;
            w_pending_nxt = 1'b0;
        end else if (w_busy_done) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_valid_tx;
        end

        if (!i_en) begin
            w_state_nxt   = ST_IDLE;
            w_msg_nxt     = SB_NONE;
            w_enc_nxt     = LANES_NONE;
            w_pending_nxt = 1'b0;
            w_valid_nxt   = 1'b0;
            w_ack_nxt     = 1'b0;
            w_fail_nxt    = 1'b0;
            w_timeout_nxt = 1'b0;
            w_cnt_clear   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SEND_INIT_REQ;
                    w_enc_nxt   = w_enc_local;
                    w_fail_nxt  = (w_enc_local == LANES_NONE);
                end
                ST_SEND_INIT_REQ: begin
                    if (w_busy_done) begin
                        w_state_nxt = ST_WAIT_INIT_RESP;
                    end else begin
                        w_go_timeout = w_expire;
                    end
                end
                ST_WAIT_INIT_RESP: begin
                    if (i_sideband_valid && (i_sideband_message == SB_INIT_RESPONSE)) begin
                        w_state_nxt = ST_SEND_DEGRADE_REQ;
                    end else begin
                        w_go_timeout = w_expire;
                    end
                end
                ST_SEND_DEGRADE_REQ: begin
                    if (w_busy_done) begin
                        w_state_nxt = ST_WAIT_DEGRADE_RESP;
                    end else begin
                        w_go_timeout = w_expire;
                    end
                end
                ST_WAIT_DEGRADE_RESP: begin
                    if (i_sideband_valid && (i_sideband_message == SB_APPLY_DEGRADE_RESPONSE)) begin
                        w_state_nxt = ST_SEND_END_REQ;
                    end else begin
                        w_go_timeout = w_expire;
                    end
                end
                ST_SEND_END_REQ: begin
                    if (w_busy_done) begin
                        w_state_nxt = ST_WAIT_END_RESP;
                    end else begin
                        w_go_timeout = w_expire;
                    end
                end
                ST_WAIT_END_RESP: begin
                    if (i_sideband_valid && (i_sideband_message == SB_END_RESPONSE)) begin
                        w_state_nxt = ST_TEST_FINISH;
                        w_ack_nxt   = 1'b1;
                    end else begin
                        w_go_timeout = w_expire;
                    end
                end
                ST_TEST_FINISH: begin
                    w_state_nxt = ST_TEST_FINISH;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_go_timeout) begin
                w_state_nxt   = ST_TEST_FINISH;
                w_timeout_nxt = 1'b1;
                w_ack_nxt     = 1'b1;
                w_valid_nxt   = 1'b0;
                w_pending_nxt = 1'b0;
            end else if ((w_state_nxt != r_state) && is_send_state(w_state_nxt)) begin
                w_msg_nxt     = request_code(w_state_nxt);
                w_pending_nxt = 1'b1;
                w_valid_nxt   = 1'b0;
                w_cnt_clear   = 1'b1;
            end else begin
                w_cnt_clear = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg          <= SB_NONE;
            r_enc          <= LANES_NONE;
            r_pending      <= 1'b0;
            r_valid_tx     <= 1'b0;
            r_test_ack     <= 1'b0;
            r_degrade_fail <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_msg          <= w_msg_nxt;
            r_enc          <= w_enc_nxt;
            r_pending      <= w_pending_nxt;
            r_valid_tx     <= w_valid_nxt;
            r_test_ack     <= w_ack_nxt;
            r_degrade_fail <= w_fail_nxt;
            r_timeout      <= w_timeout_nxt;
        end
    end

    assign o_sideband_message             = r_msg;
    assign o_sideband_data_lanes_encoding = r_enc;
    assign o_valid_tx                     = r_valid_tx;
    assign o_test_ack                     = r_test_ack;
    assign o_degrade_fail                 = r_degrade_fail;
    assign o_timeout                      = r_timeout;

endmodule

// File: tb/tb_repair_tx.sv
// Self-checking bench for repair_tx: a behavioural sideband partner drives randomized
// handshakes and the expected request order, lane map and flags come from the protocol rules.
module tb_repair_tx;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_en;
    logic       i_local_first_8_lanes_ok;
    logic       i_local_second_8_lanes_ok;
    logic [3:0] i_sideband_message;
    logic       i_sideband_valid;
    logic       i_busy_negedge_detected;
    logic       i_valid_rx;
    logic [3:0] o_sideband_message;
    logic [2:0] o_sideband_data_lanes_encoding;
    logic       o_valid_tx;
    logic       o_test_ack;
    logic       o_degrade_fail;
    logic       o_timeout;

    int checks = 0;
    int errors = 0;

    repair_tx #(.TIMEOUT_CYCLES(T)) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .i_en                           (i_en),
        .i_local_first_8_lanes_ok       (i_local_first_8_lanes_ok),
        .i_local_second_8_lanes_ok      (i_local_second_8_lanes_ok),
        .i_sideband_message             (i_sideband_message),
        .i_sideband_valid               (i_sideband_valid),
        .i_busy_negedge_detected        (i_busy_negedge_detected),
        .i_valid_rx                     (i_valid_rx),
        .o_sideband_message             (o_sideband_message),
        .o_sideband_data_lanes_encoding (o_sideband_data_lanes_encoding),
        .o_valid_tx                     (o_valid_tx),
        .o_test_ack                     (o_test_ack),
        .o_degrade_fail                 (o_degrade_fail),
        .o_timeout                      (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_en = 1'b0;
        i_local_first_8_lanes_ok = 1'b0;
        i_local_second_8_lanes_ok = 1'b0;
        i_sideband_message = 4'd0;
        i_sideband_valid = 1'b0;
        i_busy_negedge_detected = 1'b0;
        i_valid_rx = 1'b0;
        #2;
        checks++;
        if ({o_sideband_message, o_sideband_data_lanes_encoding, o_valid_tx, o_test_ack,
             o_degrade_fail, o_timeout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero", {o_sideband_message,
                     o_sideband_data_lanes_encoding, o_valid_tx, o_test_ack, o_degrade_fail, o_timeout});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({o_sideband_message, o_sideband_data_lanes_encoding, o_valid_tx, o_test_ack,
             o_degrade_fail, o_timeout} !== 11'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %b expected all zero", {o_sideband_message,
                     o_sideband_data_lanes_encoding, o_valid_tx, o_test_ack, o_degrade_fail, o_timeout});
        end
    endtask

    // Partner side of one request: wait for TX, serialise, pulse busy negedge, answer.
    task automatic serve_request(input logic [3:0] exp_msg, input logic [2:0] exp_enc,
                                 input logic [3:0] rsp, input bit send_rsp, input int delay_sel);
        int   n;
        int   ser_len;
        int   rsp_delay;
        int   noise_at;
        bit   collide;
        logic rx;
        ser_len   = $urandom_range(1, 4);
        rsp_delay = (delay_sel > 0) ? delay_sel : $urandom_range(1, 5);
        noise_at  = $urandom_range(1, 4);
        collide   = ($urandom_range(0, 3) == 0);
        n = 0;
        while (o_valid_tx !== 1'b1 && n < 8) begin
            rx = (n < 4) ? ($urandom_range(0, 2) == 0) : 1'b0;
            i_valid_rx = rx;
            tick();
            n++;
            checks++;
            if (o_valid_tx !== !rx) begin
                errors++;
                $display("FAIL valid_rise: o_valid_tx=%b expected %b (i_valid_rx was %b)", o_valid_tx, !rx, rx);
            end
        end
        i_valid_rx = 1'b0;
        checks++;
        if (o_valid_tx !== 1'b1 || o_sideband_message !== exp_msg || o_sideband_data_lanes_encoding !== exp_enc) begin
            errors++;
            $display("FAIL request: valid=%b msg=%b enc=%b expected valid=1 msg=%b enc=%b",
                     o_valid_tx, o_sideband_message, o_sideband_data_lanes_encoding, exp_msg, exp_enc);
        end
        repeat (ser_len) tick();
        checks++;
        if (o_valid_tx !== 1'b1) begin
            errors++;
            $display("FAIL valid_hold: o_valid_tx=%b expected 1", o_valid_tx);
        end
        i_busy_negedge_detected = 1'b1;
        if (collide) begin
            i_sideband_valid   = 1'b1;
            i_sideband_message = rsp;
        end
        tick();
        i_busy_negedge_detected = 1'b0;
        i_sideband_valid = 1'b0;
        checks++;
        if (o_valid_tx !== 1'b0) begin
            errors++;
            $display("FAIL valid_fall: o_valid_tx=%b expected 0", o_valid_tx);
        end
        if (send_rsp) begin
            for (int d = 1; d < rsp_delay; d++) begin
                if (d == noise_at) begin
                    i_sideband_valid   = 1'b1;
                    i_sideband_message = rsp ^ 4'($urandom_range(1, 15));
                end
                tick();
                i_sideband_valid = 1'b0;
            end
            checks++;
            if (o_valid_tx !== 1'b0 || o_sideband_message !== exp_msg) begin
                errors++;
                $display("FAIL still_waiting: valid=%b msg=%b expected valid=0 msg=%b",
                         o_valid_tx, o_sideband_message, exp_msg);
            end
            i_sideband_valid   = 1'b1;
            i_sideband_message = rsp;
            tick();
            i_sideband_valid   = 1'b0;
            i_sideband_message = 4'd0;
        end
    endtask

    task automatic run_sequence(input logic first_ok, input logic second_ok, input int delay_sel);
        logic [2:0] exp_enc;
        logic       exp_fail;
        exp_enc  = 3'(2 * int'(second_ok) + int'(first_ok));
        exp_fail = !(first_ok || second_ok);
        i_local_first_8_lanes_ok  = first_ok;
        i_local_second_8_lanes_ok = second_ok;
        i_en = 1'b1;
        tick();
        checks++;
        if (o_sideband_message !== 4'b0001 || o_degrade_fail !== exp_fail || o_valid_tx !== 1'b0) begin
            errors++;
            $display("FAIL entry: msg=%b fail=%b valid=%b expected msg=0001 fail=%b valid=0",
                     o_sideband_message, o_degrade_fail, o_valid_tx, exp_fail);
        end
        i_local_first_8_lanes_ok  = 1'($urandom);
        i_local_second_8_lanes_ok = 1'($urandom);
        serve_request(4'b0001, exp_enc, 4'b0010, 1'b1, delay_sel);
        serve_request(4'b0111, exp_enc, 4'b1000, 1'b1, delay_sel);
        serve_request(4'b0101, exp_enc, 4'b0110, 1'b1, delay_sel);
        checks++;
        if ({o_test_ack, o_degrade_fail, o_timeout, o_valid_tx} !== {1'b1, exp_fail, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL finish: ack/fail/timeout/valid=%b expected %b",
                     {o_test_ack, o_degrade_fail, o_timeout, o_valid_tx}, {1'b1, exp_fail, 1'b0, 1'b0});
        end
        repeat ($urandom_range(1, 3)) tick();
        checks++;
        if (o_test_ack !== 1'b1 || o_sideband_data_lanes_encoding !== exp_enc) begin
            errors++;
            $display("FAIL ack_hold: ack=%b enc=%b expected ack=1 enc=%b", o_test_ack,
                     o_sideband_data_lanes_encoding, exp_enc);
        end
        i_en = 1'b0;
        tick();
        checks++;
        if ({o_sideband_message, o_sideband_data_lanes_encoding, o_valid_tx, o_test_ack,
             o_degrade_fail, o_timeout} !== 11'd0) begin
            errors++;
            $display("FAIL disable_clear: got %b expected all zero", {o_sideband_message,
                     o_sideband_data_lanes_encoding, o_valid_tx, o_test_ack, o_degrade_fail, o_timeout});
        end
    endtask

    task automatic test_back_to_back();
        run_sequence(1'b1, 1'b1, 3);
        run_sequence(1'b0, 1'b1, 3);
        run_sequence(1'b0, 1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            run_sequence(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
    endtask

    task automatic test_valid_rx_block();
        i_local_first_8_lanes_ok  = 1'b1;
        i_local_second_8_lanes_ok = 1'b1;
        i_valid_rx = 1'b1;
        i_en = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (o_valid_tx !== 1'b0) begin
                errors++;
                $display("FAIL rx_block: o_valid_tx=%b expected 0 at cycle %0d", o_valid_tx, k);
            end
        end
        i_valid_rx = 1'b0;
        tick();
        checks++;
        if (o_valid_tx !== 1'b1) begin
            errors++;
            $display("FAIL rx_release: o_valid_tx=%b expected 1", o_valid_tx);
        end
        tick();
        checks++;
        if (o_valid_tx !== 1'b1 || o_sideband_message !== 4'b0001) begin
            errors++;
            $display("FAIL rx_hold: valid=%b msg=%b expected valid=1 msg=0001", o_valid_tx, o_sideband_message);
        end
        i_en = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        for (int v = 0; v < 2; v++) begin
            i_local_first_8_lanes_ok  = 1'b1;
            i_local_second_8_lanes_ok = 1'($urandom);
            i_en = 1'b1;
            tick();
            for (int k = 1; k <= T; k++) begin
                i_busy_negedge_detected = (v == 1 && k == 2);
                tick();
                i_busy_negedge_detected = 1'b0;
                if (k == T - 1) begin
                    checks++;
                    if ({o_timeout, o_test_ack, o_valid_tx} !== {1'b0, 1'b0, (v == 0)}) begin
                        errors++;
                        $display("FAIL timeout_early: timeout/ack/valid=%b expected %b",
                                 {o_timeout, o_test_ack, o_valid_tx}, {1'b0, 1'b0, (v == 0)});
                    end
                end
            end
            checks++;
            if ({o_timeout, o_test_ack, o_valid_tx} !== 3'b110) begin
                errors++;
                $display("FAIL timeout: timeout/ack/valid=%b expected 110", {o_timeout, o_test_ack, o_valid_tx});
            end
            tick();
            checks++;
            if ({o_timeout, o_test_ack, o_valid_tx} !== 3'b110) begin
                errors++;
                $display("FAIL timeout_hold: timeout/ack/valid=%b expected 110", {o_timeout, o_test_ack, o_valid_tx});
            end
            i_en = 1'b0;
            tick();
            checks++;
            if ({o_timeout, o_test_ack, o_degrade_fail, o_sideband_message} !== 7'd0) begin
                errors++;
                $display("FAIL timeout_clear: got %b expected 0", {o_timeout, o_test_ack, o_degrade_fail, o_sideband_message});
            end
        end
    endtask

    task automatic test_response_beats_timeout();
        i_local_first_8_lanes_ok  = 1'b1;
        i_local_second_8_lanes_ok = 1'b1;
        i_en = 1'b1;
        tick();
        tick();
        i_busy_negedge_detected = 1'b1;
        tick();
        i_busy_negedge_detected = 1'b0;
        repeat (T - 3) tick();
        i_sideband_valid   = 1'b1;
        i_sideband_message = 4'b0010;
        tick();
        i_sideband_valid   = 1'b0;
        i_sideband_message = 4'd0;
        checks++;
        if ({o_timeout, o_test_ack, o_sideband_message} !== {1'b0, 1'b0, 4'b0111}) begin
            errors++;
            $display("FAIL rsp_vs_timeout: timeout/ack/msg=%b expected 000111", {o_timeout, o_test_ack, o_sideband_message});
        end
        i_en = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        i_local_first_8_lanes_ok  = 1'b1;
        i_local_second_8_lanes_ok = 1'b0;
        i_en = 1'b1;
        tick();
        serve_request(4'b0001, 3'b001, 4'b0010, 1'b1, 0);
        serve_request(4'b0111, 3'b001, 4'b1000, 1'b0, 0);
        i_en = 1'b0;
        tick();
        checks++;
        if ({o_sideband_message, o_sideband_data_lanes_encoding, o_valid_tx, o_test_ack,
             o_degrade_fail, o_timeout} !== 11'd0) begin
            errors++;
            $display("FAIL abort_clear: got %b expected all zero", {o_sideband_message,
                     o_sideband_data_lanes_encoding, o_valid_tx, o_test_ack, o_degrade_fail, o_timeout});
        end
        run_sequence(1'b0, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_valid_rx_block();
        test_timeout();
        test_response_beats_timeout();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/repair_tx.md
# repair_tx

Initiator half of the MBTRAIN.REPAIR handshake. Drives the local request sequence {INIT_REQUEST, APPLY_DEGRADE_REQUEST (with lane encoding), END_REQUEST} onto the sideband and waits for the matching partner responses. Runs in parallel with the responder half (repair_rx), sharing the sideband TX path. Reports completion, degrade failure and timeout back to the MBTRAIN controller.

## Interface
- TIMEOUT_CYCLES, 8000: per-handshake response timeout in clk cycles (8 ms at 1 MHz sideband clock); 16-bit counter.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  substate enable from MBTRAIN; low = abort to IDLE
- i_local_first_8_lanes_ok  in  1  local result, lanes 0-7 usable
- i_local_second_8_lanes_ok  in  1  local result, lanes 8-15 usable
- i_sideband_message  in  4  decoded received sideband message
- i_sideband_valid  in  1  i_sideband_message valid this cycle
- i_busy_negedge_detected  in  1  sideband TX finished serialising current message
- i_valid_rx  in  1  responder half currently owns sideband TX
- o_sideband_message  out  4  message to transmit
- o_sideband_data_lanes_encoding  out  3  lane map carried with APPLY_DEGRADE_REQUEST
- o_valid_tx  out  1  request sideband TX of o_sideband_message
- o_test_ack  out  1  sequence finished (success, degrade fail or timeout)
- o_degrade_fail  out  1  no usable 8-lane half
- o_timeout  out  1  a response did not arrive within TIMEOUT_CYCLES

## Operation
- Codes: INIT_REQUEST 0001, INIT_RESPONSE 0010, END_REQUEST 0101, END_RESPONSE 0110, APPLY_DEGRADE_REQUEST 0111, APPLY_DEGRADE_RESPONSE 1000.
- Encoding is latched on the IDLE->SEND_INIT_REQ transition and held:
  - both halves ok: 011
  - first half only: 001
  - second half only: 010
  - neither: 000, and o_degrade_fail=1 is latched at the same time.
- States:
  - IDLE -> SEND_INIT_REQ when i_en=1.
  - SEND_INIT_REQ -> WAIT_INIT_RESP on i_busy_negedge_detected while o_valid_tx=1.
  - WAIT_INIT_RESP -> SEND_DEGRADE_REQ on i_sideband_valid with INIT_RESPONSE.
  - SEND_DEGRADE_REQ -> WAIT_DEGRADE_RESP on busy negedge.
  - WAIT_DEGRADE_RESP -> SEND_END_REQ on APPLY_DEGRADE_RESPONSE.
  - SEND_END_REQ -> WAIT_END_RESP on busy negedge.
  - WAIT_END_RESP -> TEST_FINISH on END_RESPONSE.
  - TEST_FINISH -> IDLE when i_en=0.
- Any non-matching received message is ignored.
- Encoding 000 is still sent. The sequence completes normally; o_degrade_fail informs MBTRAIN, which routes to TRAINERROR.
- Valid handshake:
  - On entry to each SEND_* state, o_sideband_message is loaded and a pending flag is set.
  - o_valid_tx rises when pending=1 and i_valid_rx=0. The pending flag clears at the same time.
  - o_valid_tx falls on i_busy_negedge_detected.
  - o_valid_tx is never raised while i_valid_rx=1.
- Timeout:
  - Counter clears on entry to each SEND_* state and increments in every SEND_*/WAIT_* cycle.
  - On reaching TIMEOUT_CYCLES-1: state goes to TEST_FINISH, o_timeout=1, o_valid_tx=0.

## Timing
- Reset and IDLE values: all outputs 0, state IDLE, counter 0, pending 0.
- i_en rises at edge N: SEND_INIT_REQ from N+1. o_sideband_message=0001 and pending set at N+1. o_valid_tx=1 from N+2 if i_valid_rx=0 at N+1.
- A matching response valid in cycle k: next SEND_* state at k+1; o_valid_tx no earlier than k+2.
- o_test_ack rises in the first TEST_FINISH cycle and holds until i_en=0. It is cleared, with o_timeout and o_degrade_fail, in the cycle IDLE is re-entered.
- i_en=0 in any state: IDLE next edge. o_valid_tx, pending and o_sideband_message are cleared on that edge.
- i_busy_negedge_detected and a response in the same cycle while in SEND_*: only the busy negedge is acted on; the response is ignored.
- Timeout and matching response in the same cycle: the response wins.

## Structure
- Shared package ltsm_sb_pkg holds the sideband message codes, the lane-encoding constants and the state typedef.
- Optional sub-module ltsm_timeout_cnt: parameterised clear/enable/expire counter, reusable by the other MBTRAIN substates.

## Test plan
- Both halves ok, partner answers each request 3 cycles after its busy negedge:
  - Messages 0001, 0111 (encoding 011), 0101 are sent in order.
  - o_test_ack=1; o_degrade_fail=0; o_timeout=0.
- Only the second half ok: encoding 010 accompanies 0111. Neither half ok: encoding 000, o_degrade_fail=1, o_test_ack=1.
- i_valid_rx held high for 5 cycles across SEND_INIT_REQ entry: o_valid_tx stays 0 until the cycle after i_valid_rx falls, then rises once.
- No INIT_RESPONSE received: o_timeout=1 and o_test_ack=1 exactly TIMEOUT_CYCLES cycles after SEND_INIT_REQ entry (run with TIMEOUT_CYCLES=20); o_valid_tx=0.
- i_en dropped while in WAIT_DEGRADE_RESP: IDLE next cycle with all outputs 0. Re-enabling restarts from 0001 with a freshly latched encoding.
